// File: rtl/cordic_vec_controller_if.sv
// Request/status and datapath-control bundle between the CORDIC vectoring sequencer,
// its requester and the x/y/z datapath.
interface cordic_vec_controller_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 start;
  logic                 x_sign;
  logic                 y_sign;
  logic                 busy;
  logic                 ld_init;
  logic                 prerot_en;
  logic                 prerot_dir;
  logic                 iter_en;
  logic                 dir;
  logic [CNT_WIDTH-1:0] shift_amt;
  logic [CNT_WIDTH-1:0] lut_addr;
  logic                 done;

  // Requester/datapath side: issues start, reports the datapath signs.
  modport master (
    output start, x_sign, y_sign,
    input  busy, ld_init, prerot_en, prerot_dir, iter_en, dir, shift_amt, lut_addr, done
  );

  // Sequencer side.
  modport slave (
    input  start, x_sign, y_sign,
    output busy, ld_init, prerot_en, prerot_dir, iter_en, dir, shift_amt, lut_addr, done
  );
endinterface

// File: rtl/cordic_vec_controller.sv
// Sequencer for the iterative CORDIC vectoring datapath: load, quadrant pre-rotation,
// ITERATIONS sign(y)-steered micro-rotations, then a one-cycle done pulse.
module cordic_vec_controller #(
  parameter int WORD_WIDTH = 16,
  parameter int ITERATIONS = 16,
  parameter int CNT_WIDTH  = 4
) (
  input logic                     clk,
  input logic                     rst,
  cordic_vec_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PREROT = 3'd2,
    S_ITER   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // An out-of-range configuration never accepts a request rather than running a bogus count.
  localparam logic PARAMS_OK = (ITERATIONS >= 1) && (ITERATIONS <= (1 << CNT_WIDTH)) &&
                               (WORD_WIDTH >= 1);
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(ITERATIONS - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_iter_cnt;
  logic [CNT_WIDTH-1:0] w_iter_cnt_next;

  logic                 w_busy;
  logic                 w_ld_init;
  logic                 w_prerot_en;
  logic                 w_prerot_dir;
  logic                 w_iter_en;
  logic                 w_dir;
  logic [CNT_WIDTH-1:0] w_shift_amt;
  logic                 w_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_iter_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_iter_cnt <= w_iter_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_iter_cnt_next = r_iter_cnt;
    w_busy          = 1'b1;
    w_ld_init       = 1'b0;
    w_prerot_en     = 1'b0;
    w_prerot_dir    = 1'b0;
    w_iter_en       = 1'b0;
    w_dir           = 1'b0;
    w_shift_amt     = '0;
    w_done          = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy          = 1'b0;
        w_iter_cnt_next = '0;
        if (bus.start && PARAMS_OK) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_ld_init    = 1'b1;
        w_state_next = S_PREROT;
      end
      S_PREROT: begin
        // Negative x sits in the left half-plane; rotate it by +/-90 deg first.
        w_prerot_en     = bus.x_sign;
        w_prerot_dir    = bus.y_sign;
        w_iter_cnt_next = '0;
        w_state_next    = S_ITER;
      end
      S_ITER: begin
        w_iter_en   = 1'b1;
        w_dir       = bus.y_sign;
        w_shift_amt = r_iter_cnt;
        if (r_iter_cnt == LAST_ITER) begin
          w_iter_cnt_next = '0;
          w_state_next    = S_DONE;
        end else begin
          w_iter_cnt_next = r_iter_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_busy          = 1'b0;
        w_iter_cnt_next = '0;
        w_state_next    = S_IDLE;
      end
    endcase
  end

  assign bus.busy       = w_busy;
  assign bus.ld_init    = w_ld_init;
  assign bus.prerot_en  = w_prerot_en;
  assign bus.prerot_dir = w_prerot_dir;
  assign bus.iter_en    = w_iter_en;
  assign bus.dir        = w_dir;
  assign bus.shift_amt  = w_shift_amt;
  assign bus.lut_addr   = w_shift_amt;
  assign bus.done       = w_done;

endmodule

// File: tb/tb_cordic_vec_controller.sv
// Randomized bench for cordic_vec_controller against a cycle-offset reference model.
module tb_cordic_vec_controller;
  localparam int N  = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_vec_controller_if #(.CNT_WIDTH(CW)) bus();

  cordic_vec_controller #(
    .WORD_WIDTH(16),
    .ITERATIONS(N),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int n_ops  = 0;
  int cyc    = 0;
  // Model: 0 = idle, k>0 = k-th cycle after the accepting edge of the current operation.
  int phase  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic it;
    it = (phase >= 3) && (phase <= N + 2);
    chk("busy",       32'(bus.busy),       32'(phase != 0));
    chk("ld_init",    32'(bus.ld_init),    32'(phase == 1));
    chk("prerot_en",  32'(bus.prerot_en),  32'((phase == 2) && bus.x_sign));
    chk("prerot_dir", 32'(bus.prerot_dir), 32'((phase == 2) && bus.y_sign));
    chk("iter_en",    32'(bus.iter_en),    32'(it));
    chk("dir",        32'(bus.dir),        32'(it && bus.y_sign));
    chk("shift_amt",  32'(bus.shift_amt),  it ? 32'(phase - 3) : 32'd0);
    chk("lut_addr",   32'(bus.lut_addr),   it ? 32'(phase - 3) : 32'd0);
    chk("done",       32'(bus.done),       32'(phase == N + 3));
    if (phase == N + 3) begin
      n_ops++;
      $display("op %0d: done at cycle %0d", n_ops, cyc);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, drive new inputs, check.
  task automatic step(input logic rst_v, input logic start_v);
    @(posedge clk);
    cyc++;
    if (rst)                phase = 0;
    else if (phase == 0)    phase = bus.start ? 1 : 0;
    else if (phase == N + 3) phase = 0;
    else                    phase = phase + 1;
    #1;
    rst        = rst_v;
    bus.start  = start_v;
    bus.x_sign = 1'($urandom);
    bus.y_sign = 1'($urandom);
    #1;
    check_outputs();
  endtask

  initial begin
    int lat;
    int guard;
    bus.start  = 1'b0;
    bus.x_sign = 1'b0;
    bus.y_sign = 1'b0;

    // Reset for two edges, then idle with start low.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Single operation with latency measurement.
    step(1'b0, 1'b1);
    lat = 0;
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b0);
      if (bus.done === 1'b1 && lat == 0) lat = k;
    end
    chk("latency", 32'(lat), 32'(N + 3));

    // Start held high: back-to-back operations, no extra loads or dones.
    repeat (65) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (24) step(1'b0, 1'b0);

    // Reset mid-operation at iteration 7, then a fresh full-latency operation.
    step(1'b0, 1'b1);
    guard = 0;
    step(1'b0, 1'b0);
    while (phase != 10 && guard < 30) begin
      step(1'b0, 1'b0);
      guard++;
    end
    chk("reach_iter7", 32'(phase == 10), 32'd1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    lat = 0;
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b0);
      if (bus.done === 1'b1 && lat == 0) lat = k;
    end
    chk("latency_after_rst", 32'(lat), 32'(N + 3));

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
